hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Hazard and forwarding controller for the 5-stage pipeline. Tracks the destination registers of the instructions in EX, MEM and WB, and drives the ID-stage operand forwarding selects (fwd_a / fwd_b). It also generates the load-use and branch-compare stalls, and the IF/ID flush on taken branches and jumps. The block sits beside the decode stage and sequences the PC, IF/ID and ID/EX registers.

## Interface
- No parameters. Forwarding select encoding is fixed:
  - PortSel1 = 2'b00: register file.
  - PortSel2 = 2'b01: EX ALU result.
  - PortSel3 = 2'b10: MEM result.
  - PortSel4 = 2'b11: WB write data.
- clk  input  1  pipeline clock; state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  IF/ID holds a real instruction.
- id_rs, id_rt  input  5 each  source register numbers of the ID instruction.
- id_uses_rs, id_uses_rt  input  1 each  the instruction reads that source.
- id_is_branch  input  1  beq/bne; operands are compared in ID.
- id_is_jump  input  1  j-type.
- id_branch_taken  input  1  ID compare result; meaningful only with id_is_branch.
- id_reg_write  input  1  the ID instruction writes a register.
- id_mem_read  input  1  the ID instruction is a load.
- id_reg_des  input  5  destination register of the ID instruction.
- fwd_a, fwd_b  output  2 each  operand 1 / operand 2 port select.
- pc_write  output  1  PC may advance.
- ifid_write  output  1  IF/ID may load.
- idex_bubble  output  1  load a NOP into ID/EX.
- ifid_flush  output  1  clear IF/ID (squash the fetched instruction).
- stall_cnt  output  16  count of stall cycles, saturating.
- flush_cnt  output  16  count of flush cycles, saturating.

## Operation
- Tracking state: three slots, EX, MEM and WB. Each slot holds {valid, reg_write, mem_read, des[4:0]}.
- A source src "hits" slot S when all of these are true: S.valid, S.reg_write, S.des == src, src != 0, and the matching uses bit is set.
- stall = id_valid & (H1 | H2 | H3), where:
  - H1: an EX slot hit with EX.mem_read. This is the load-use case.
  - H2: an EX slot hit with id_is_branch. An ALU result is not ready for the ID compare.
  - H3: a MEM slot hit with MEM.mem_read and id_is_branch. Load data is not ready for the compare.
- pc_write = ifid_write = ~stall. idex_bubble = stall.
- Forward select per operand, in priority order:
  - EX hit → PortSel2.
  - else MEM hit → PortSel3.
  - else WB hit → PortSel4.
  - else PortSel1.
  - Register 0 always selects PortSel1.
  - Selects are computed whenever id_valid is set, even while stalling. When id_valid = 0 they are PortSel1.
- ifid_flush = id_valid & ~stall & (id_is_jump | (id_is_branch & id_branch_taken)).
- A taken branch that is also stalling does not flush. The flush occurs in the cycle the stall clears.
- Slot recording: EX.reg_write is recorded as id_reg_write & (id_reg_des != 0). A write to $0 is never tracked.
- Counters: stall_cnt increments in each cycle where stall = 1. flush_cnt increments in each cycle where ifid_flush = 1. Both hold at 16'hFFFF.

## Timing
- All control outputs are combinational from the slot registers and the ID inputs. They are valid before the next rising edge. ID consumes fwd_a/fwd_b at negedge.
- Rising edge, no stall:
  - EX ← {id_valid, recorded reg_write, id_mem_read, id_reg_des}.
  - MEM ← EX.
  - WB ← MEM.
- Rising edge, stall: EX ← bubble (all fields 0). MEM ← EX and WB ← MEM still advance.
- Stall length:
  - Load-use: 1 cycle.
  - Branch on an EX ALU producer: 1 cycle, then PortSel3.
  - Branch on a load in EX: 2 cycles (H1, then H3), then PortSel4.
- ifid_flush lasts exactly one cycle per taken branch or jump.
- Reset (asynchronous, any cycle, including mid-stall):
  - All slots invalid; counters 0.
  - While rst is high, outputs are forced to: fwd_a = fwd_b = 2'b00, pc_write = ifid_write = 1, idex_bubble = 0, ifid_flush = 0.
- After reset release, the first edge records the ID instruction normally.

## Test plan
- ALU back-to-back: add $3,$1,$2 then sub $4,$3,$1.
  - Expected: second instruction in ID gets fwd_a = 2'b01 and no stall.
  - Next instruction reading $3 gets 2'b10; the one after gets 2'b11; then 2'b00.
- Load-use: lw $5,0($1) then add $6,$5,$5.
  - Expected: stall = 1 for exactly one cycle (pc_write = 0, idex_bubble = 1).
  - Then fwd_a = fwd_b = 2'b10; stall_cnt = 1.
- Branch after load: lw $7 then beq $7,$0,taken.
  - Expected: 2 stall cycles, then fwd_a = 2'b11.
  - ifid_flush pulses for 1 cycle only after the stalls; flush_cnt = 1.
- Register zero and priority:
  - addi $0 followed by a reader of $0 → PortSel1, no stall.
  - $3 written in both EX and MEM → reader gets PortSel2.
- Jump during stall: j issued while a load-use hazard holds ID.
  - Expected: no flush while stalled; single flush cycle afterward.
- Asynchronous reset asserted mid-stall, between clock edges.
  - Expected: outputs return immediately to reset values; counters = 0.
  - After release: no spurious forwarding from stale slots.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks EX/MEM/WB destination registers for the 5-stage pipeline,
// drives ID operand forwarding selects, load-use / branch-compare stalls and
// the IF/ID flush on taken branches and jumps.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_branch,
  input  logic        id_is_jump,
  input  logic        id_branch_taken,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic [4:0]  id_reg_des,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int unsigned RegW = 5;
  localparam int unsigned CntW = 16;
  localparam int unsigned SelW = 2;

  localparam logic [SelW-1:0] PortSel1 = 2'b00;  // register file
  localparam logic [SelW-1:0] PortSel2 = 2'b01;  // EX ALU result
  localparam logic [SelW-1:0] PortSel3 = 2'b10;  // MEM result
  localparam logic [SelW-1:0] PortSel4 = 2'b11;  // WB write data

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic [RegW-1:0] des;
  } slot_t;

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d, mem_d, wb_d;

  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CntW-1:0] flush_cnt_q, flush_cnt_d;

  logic stall_c;
  logic flush_c;
  logic [SelW-1:0] sel_a_c, sel_b_c;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic ex_hit, mem_hit;

  // A source hits a slot when that slot will write the same non-zero register
  function automatic logic slot_hit(input slot_t s, input logic [RegW-1:0] src,
                                    input logic uses);
    return s.valid & s.reg_write & (s.des == src) & (src != RegW'(0)) & uses;
  endfunction

  // Hazard detection and forward select priority EX > MEM > WB > regfile
  always_comb begin
    ex_hit_a  = slot_hit(ex_q,  id_rs, id_uses_rs);
    ex_hit_b  = slot_hit(ex_q,  id_rt, id_uses_rt);
    mem_hit_a = slot_hit(mem_q, id_rs, id_uses_rs);
    mem_hit_b = slot_hit(mem_q, id_rt, id_uses_rt);
    wb_hit_a  = slot_hit(wb_q,  id_rs, id_uses_rs);
    wb_hit_b  = slot_hit(wb_q,  id_rt, id_uses_rt);
    ex_hit    = ex_hit_a | ex_hit_b;
    mem_hit   = mem_hit_a | mem_hit_b;

    stall_c = ~rst & id_valid &
              ((ex_hit & ex_q.mem_read) |
               (ex_hit & id_is_branch) |
               (mem_hit & mem_q.mem_read & id_is_branch));

    // A stalled branch/jump keeps its flush until the stall clears
    flush_c = ~rst & id_valid & ~stall_c &
              (id_is_jump | (id_is_branch & id_branch_taken));

    sel_a_c = PortSel1;
    if (ex_hit_a)       sel_a_c = PortSel2;
    else if (mem_hit_a) sel_a_c = PortSel3;
    else if (wb_hit_a)  sel_a_c = PortSel4;

    sel_b_c = PortSel1;
    if (ex_hit_b)       sel_b_c = PortSel2;
    else if (mem_hit_b) sel_b_c = PortSel3;
    else if (wb_hit_b)  sel_b_c = PortSel4;
  end

  // Output drive; reset forces the free-running pipeline values
  always_comb begin
    fwd_a       = PortSel1;
    fwd_b       = PortSel1;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (!rst) begin
      if (id_valid) begin
        fwd_a = sel_a_c;
        fwd_b = sel_b_c;
      end
      pc_write    = ~stall_c;
      ifid_write  = ~stall_c;
      idex_bubble = stall_c;
      ifid_flush  = flush_c;
    end
  end

  // Next slot contents and saturating counters
  always_comb begin
    ex_d        = '0;
    mem_d       = ex_q;
    wb_d        = mem_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!stall_c) begin
      ex_d.valid     = id_valid;
      ex_d.reg_write = id_reg_write & (id_reg_des != RegW'(0));
      ex_d.mem_read  = id_mem_read;
      ex_d.des       = id_reg_des;
    end
    if (stall_c && (stall_cnt_q != {CntW{1'b1}}))
      stall_cnt_d = stall_cnt_q + CntW'(1);
    if (flush_c && (flush_cnt_q != {CntW{1'b1}}))
      flush_cnt_d = flush_cnt_q + CntW'(1);
  end

  // Slot and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt;
  logic        id_is_branch, id_is_jump, id_branch_taken;
  logic        id_reg_write, id_mem_read;
  logic [4:0]  id_reg_des;
  logic [1:0]  fwd_a, fwd_b;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_is_jump(id_is_jump),
    .id_branch_taken(id_branch_taken), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_reg_des(id_reg_des),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic br,
                       input logic jmp, input logic tkn, input logic rw,
                       input logic mr, input logic [4:0] des);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_is_branch = br; id_is_jump = jmp; id_branch_taken = tkn;
    id_reg_write = rw; id_mem_read = mr; id_reg_des = des;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock; leaves time at posedge + 1
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nop();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    nop();
    rst = 1'b1;
    @(posedge clk);
    #2;
    drive(1, 3, 3, 1, 1, 1, 1, 1, 1, 1, 3);
    #1;
    checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || pc_write !== 1'b1 ||
        ifid_write !== 1'b1 || idex_bubble !== 1'b0 || ifid_flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got fa=%b fb=%b pw=%b iw=%b bub=%b fl=%b exp 00 00 1 1 0 0",
               fwd_a, fwd_b, pc_write, ifid_write, idex_bubble, ifid_flush);
    end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters got %0d %0d exp 0 0", stall_cnt, flush_cnt);
    end
    nop();
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu_chain();
    do_reset();
    drive(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 3);      // add $3,$1,$2
    #1;
    checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      errors++; $display("FAIL alu_first got %b %b exp 00 00", fwd_a, fwd_b);
    end
    step();
    drive(1, 3, 1, 1, 1, 0, 0, 0, 1, 0, 4);      // sub $4,$3,$1
    #1;
    checks++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b00 || pc_write !== 1'b1) begin
      errors++; $display("FAIL alu_ex got fa=%b fb=%b pw=%b exp 01 00 1", fwd_a, fwd_b, pc_write);
    end
    step();
    drive(1, 3, 0, 1, 1, 0, 0, 0, 1, 0, 8);      // or $8,$3,$0
    #1;
    checks++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
      errors++; $display("FAIL alu_mem got %b %b exp 10 00", fwd_a, fwd_b);
    end
    step();
    drive(1, 3, 0, 1, 0, 0, 0, 0, 1, 0, 9);
    #1;
    checks++;
    if (fwd_a !== 2'b11) begin
      errors++; $display("FAIL alu_wb got %b exp 11", fwd_a);
    end
    step();
    drive(1, 3, 0, 1, 0, 0, 0, 0, 1, 0, 10);
    #1;
    checks++;
    if (fwd_a !== 2'b00 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL alu_retired got fa=%b sc=%0d exp 00 0", fwd_a, stall_cnt);
    end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 5);      // lw $5,0($1)
    step();
    drive(1, 5, 5, 1, 1, 0, 0, 0, 1, 0, 6);      // add $6,$5,$5
    #1;
    checks++;
    if (pc_write !== 1'b0 || ifid_write !== 1'b0 || idex_bubble !== 1'b1 || fwd_a !== 2'b01) begin
      errors++;
      $display("FAIL load_use_stall got pw=%b iw=%b bub=%b fa=%b exp 0 0 1 01",
               pc_write, ifid_write, idex_bubble, fwd_a);
    end
    step();
    #1;
    checks++;
    if (pc_write !== 1'b1 || idex_bubble !== 1'b0 || fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
      errors++;
      $display("FAIL load_use_fwd got pw=%b bub=%b fa=%b fb=%b exp 1 0 10 10",
               pc_write, idex_bubble, fwd_a, fwd_b);
    end
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL load_use_cnt got %0d exp 1", stall_cnt);
    end
    step();
    nop();
    step();
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL load_use_cnt_hold got %0d exp 1", stall_cnt);
    end
  endtask

  task automatic test_branch_alu();
    do_reset();
    drive(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 3);      // add $3
    step();
    drive(1, 3, 0, 1, 1, 1, 0, 0, 0, 0, 0);      // beq $3,$0 not taken
    #1;
    checks++;
    if (pc_write !== 1'b0 || idex_bubble !== 1'b1) begin
      errors++; $display("FAIL br_alu_stall got pw=%b bub=%b exp 0 1", pc_write, idex_bubble);
    end
    step();
    #1;
    checks++;
    if (pc_write !== 1'b1 || fwd_a !== 2'b10 || ifid_flush !== 1'b0) begin
      errors++; $display("FAIL br_alu_after got pw=%b fa=%b fl=%b exp 1 10 0", pc_write, fwd_a, ifid_flush);
    end
    step();
  endtask

  task automatic test_branch_load();
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 7);      // lw $7
    step();
    drive(1, 7, 0, 1, 1, 1, 0, 1, 0, 0, 0);      // beq $7,$0 taken
    #1;
    checks++;
    if (pc_write !== 1'b0 || ifid_flush !== 1'b0) begin
      errors++; $display("FAIL br_ld_stall1 got pw=%b fl=%b exp 0 0", pc_write, ifid_flush);
    end
    step();
    #1;
    checks++;
    if (pc_write !== 1'b0 || ifid_flush !== 1'b0 || fwd_a !== 2'b10) begin
      errors++; $display("FAIL br_ld_stall2 got pw=%b fl=%b fa=%b exp 0 0 10", pc_write, ifid_flush, fwd_a);
    end
    step();
    #1;
    checks++;
    if (pc_write !== 1'b1 || fwd_a !== 2'b11 || ifid_flush !== 1'b1) begin
      errors++; $display("FAIL br_ld_release got pw=%b fa=%b fl=%b exp 1 11 1", pc_write, fwd_a, ifid_flush);
    end
    checks++;
    if (stall_cnt !== 16'd2 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL br_ld_cnt1 got sc=%0d fc=%0d exp 2 0", stall_cnt, flush_cnt);
    end
    step();
    nop();
    #1;
    checks++;
    if (ifid_flush !== 1'b0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin
      errors++; $display("FAIL br_ld_cnt2 got fl=%b fc=%0d sc=%0d exp 0 1 2", ifid_flush, flush_cnt, stall_cnt);
    end
    step();
  endtask

  task automatic test_zero_priority();
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0);      // addi $0,$1,5
    step();
    drive(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);      // reader of $0 (branch)
    #1;
    checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || pc_write !== 1'b1) begin
      errors++; $display("FAIL zero_reg got fa=%b fb=%b pw=%b exp 00 00 1", fwd_a, fwd_b, pc_write);
    end
    step();
    drive(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 3);      // add $3
    step();
    drive(1, 3, 0, 1, 0, 0, 0, 0, 1, 0, 3);      // addi $3,$3,1
    step();
    drive(1, 3, 3, 1, 1, 0, 0, 0, 1, 0, 4);      // reader $3,$3
    #1;
    checks++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
      errors++; $display("FAIL priority_ex got %b %b exp 01 01", fwd_a, fwd_b);
    end
    drive(1, 3, 3, 0, 1, 0, 0, 0, 1, 0, 4);      // rs not used
    #1;
    checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b01) begin
      errors++; $display("FAIL uses_bit got %b %b exp 00 01", fwd_a, fwd_b);
    end
    drive(0, 3, 3, 1, 1, 0, 0, 0, 1, 0, 4);      // invalid ID slot
    #1;
    checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      errors++; $display("FAIL id_invalid got %b %b exp 00 00", fwd_a, fwd_b);
    end
    step();
  endtask

  task automatic test_jump_stall();
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 5);      // lw $5
    step();
    drive(1, 5, 0, 1, 0, 0, 1, 0, 0, 0, 0);      // jump reading $5
    #1;
    checks++;
    if (pc_write !== 1'b0 || ifid_flush !== 1'b0) begin
      errors++; $display("FAIL jump_stalled got pw=%b fl=%b exp 0 0", pc_write, ifid_flush);
    end
    step();
    #1;
    checks++;
    if (pc_write !== 1'b1 || ifid_flush !== 1'b1) begin
      errors++; $display("FAIL jump_flush got pw=%b fl=%b exp 1 1", pc_write, ifid_flush);
    end
    step();
    nop();
    #1;
    checks++;
    if (ifid_flush !== 1'b0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL jump_cnt got fl=%b fc=%0d sc=%0d exp 0 1 1", ifid_flush, flush_cnt, stall_cnt);
    end
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 5);      // lw $5
    step();
    drive(1, 5, 5, 1, 1, 0, 0, 0, 1, 0, 6);      // load-use stall
    step();
    drive(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 9);      // lw $9
    step();
    drive(1, 9, 0, 1, 0, 1, 0, 1, 0, 0, 0);      // taken beq on $9
    #1;
    checks++;
    if (pc_write !== 1'b0 || stall_cnt !== 16'd1 || fwd_a !== 2'b01) begin
      errors++; $display("FAIL ar_pre got pw=%b sc=%0d fa=%b exp 0 1 01", pc_write, stall_cnt, fwd_a);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1 || idex_bubble !== 1'b0 ||
        ifid_flush !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      errors++;
      $display("FAIL ar_forced got pw=%b iw=%b bub=%b fl=%b fa=%b fb=%b exp 1 1 0 0 00 00",
               pc_write, ifid_write, idex_bubble, ifid_flush, fwd_a, fwd_b);
    end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL ar_counters got %0d %0d exp 0 0", stall_cnt, flush_cnt);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (fwd_a !== 2'b00 || pc_write !== 1'b1 || ifid_flush !== 1'b1) begin
      errors++; $display("FAIL ar_release got fa=%b pw=%b fl=%b exp 00 1 1", fwd_a, pc_write, ifid_flush);
    end
    step();
    drive(1, 9, 5, 1, 1, 0, 0, 0, 1, 0, 6);
    #1;
    checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || pc_write !== 1'b1 || flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL ar_no_stale got fa=%b fb=%b pw=%b fc=%0d exp 00 00 1 1", fwd_a, fwd_b, pc_write, flush_cnt);
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    nop();
    test_reset();
    test_alu_chain();
    test_load_use();
    test_branch_alu();
    test_branch_load();
    test_zero_priority();
    test_jump_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
